// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared defaults, scanner state type and byte-merge helper
package led_scan_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_SEG_W    = 8;
  localparam int DEF_SCAN_DIV = 50000;
  localparam int MAX_W        = 1024;
  localparam int MAX_B        = MAX_W / 8;
  typedef enum logic {IDLE, RUN} scan_state_t;
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, new_w,
                                                  input logic [MAX_B-1:0] strb);
    byte_merge = old_w;
    for (int i = 0; i < MAX_B; i++)
      if (strb[i]) byte_merge[8*i +: 8] = new_w[8*i +: 8];
  endfunction
endpackage

// File: rtl/led_scan_ram_if.sv
// led_scan_ram_if: store/load bus plus display scan pins
interface led_scan_ram_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int SEG_W  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                re;
  logic [ADDR_W-1:0]   raddr;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                scan_en;
  logic [DEPTH-1:0]    scan_sel;
  logic [SEG_W-1:0]    scan_data;
  logic [ADDR_W-1:0]   scan_idx;
  logic                scan_tick;
  modport master (output we, waddr, wdata, wstrb, re, raddr, scan_en,
                  input rdata, rvalid, scan_sel, scan_data, scan_idx, scan_tick);
  modport slave (input we, waddr, wdata, wstrb, re, raddr, scan_en,
                 output rdata, rvalid, scan_sel, scan_data, scan_idx, scan_tick);
endinterface

// File: rtl/led_scan_seq.sv
// led_scan_seq: digit prescaler, index counter, run/idle FSM and one-hot select
module led_scan_seq
  import led_scan_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] idx_nxt,
  output logic [ADDR_W-1:0] idx,
  output logic [DEPTH-1:0]  sel,
  output logic              tick
);
  localparam int PW = $clog2(SCAN_DIV);
  scan_state_t state;
  logic [PW-1:0] pre;
  logic wrap;
  assign wrap = state == RUN && pre == PW'(SCAN_DIV - 1);
  // next index is exported so the segment data can be fetched for the same edge
  assign idx_nxt = (!en || state == IDLE) ? '0 :
                   wrap ? (idx == ADDR_W'(DEPTH - 1) ? '0 : idx + ADDR_W'(1)) : idx;
  // FSM with registered index, select and tick so all scan outputs change together
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pre   <= '0;
      idx   <= '0;
      sel   <= '0;
      tick  <= 1'b0;
    end else begin
      state <= en ? RUN : IDLE;
      pre   <= (state == RUN && en && !wrap) ? pre + PW'(1) : '0;
      idx   <= idx_nxt;
      sel   <= en ? DEPTH'(1) << idx_nxt : '0;
      tick  <= en && wrap;
    end
endmodule

// File: rtl/led_scan_ram.sv
// led_scan_ram: byte-masked register-file RAM with registered read and display scanner
module led_scan_ram
  import led_scan_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int SEG_W    = DEF_SEG_W,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input logic            clk,
  input logic            reset,
  led_scan_ram_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = DATA_W / 8;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx_nxt;
  logic              w_ok, r_ok;
  logic [DATA_W-1:0] w_merged, r_word;
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o, n,
                                              input logic [NB-1:0] s);
    return DATA_W'(byte_merge(MAX_W'(o), MAX_W'(n), MAX_B'(s)));
  endfunction
  // widened compares keep non-power-of-two depths from aliasing
  assign w_ok     = bus.we && ({1'b0, bus.waddr} < (ADDR_W + 1)'(DEPTH));
  assign r_ok     = {1'b0, bus.raddr} < (ADDR_W + 1)'(DEPTH);
  assign w_merged = merge(mem[bus.waddr], bus.wdata, bus.wstrb);
  assign r_word   = !r_ok ? '0 : (w_ok && bus.waddr == bus.raddr) ? w_merged : mem[bus.raddr];
  // storage: byte-masked write of the merged word
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (w_ok) mem[bus.waddr] <= w_merged;
  // read port: write-first bypass, rdata holds when idle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      bus.rvalid <= bus.re;
      if (bus.re) bus.rdata <= r_word;
    end
  // segment data fetched with the next index so it lines up with scan_sel
  always_ff @(posedge clk or negedge reset)
    if (!reset) bus.scan_data <= '0;
    else bus.scan_data <= bus.scan_en ? mem[idx_nxt][SEG_W-1:0] : '0;
  led_scan_seq #(.DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV)) u_seq (
    .clk     (clk),
    .reset   (reset),
    .en      (bus.scan_en),
    .idx_nxt (idx_nxt),
    .idx     (bus.scan_idx),
    .sel     (bus.scan_sel),
    .tick    (bus.scan_tick)
  );
endmodule
